// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_e  : sequencer states (run, waiting on data memory, halted on timeout)
//   REG_ZERO : architectural zero register, never a real dependency source
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StHalt    = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator (purely combinational).
// Ports:
//   id_rs_i, id_rt_i     : source register fields of the instruction in ID
//   id_uses_rt_i         : ID instruction actually reads rt
//   ex_mem_read_i        : instruction in EX is a load
//   ex_write_reg_i       : destination register of the EX instruction
//   load_use_o           : ID consumes the result of the load currently in EX
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_uses_rt_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_write_reg_i,
  output logic       load_use_o
);

  logic rs_match;
  logic rt_match;

  always_comb begin
    rs_match   = (ex_write_reg_i == id_rs_i);
    rt_match   = id_uses_rt_i && (ex_write_reg_i == id_rt_i);
    // Writes to r0 are discarded, so they never create a dependency.
    load_use_o = ex_mem_read_i && (ex_write_reg_i != REG_ZERO) && (rs_match || rt_match);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central enable/flush sequencer for the PC and the IF/ID, ID/EX, EX/MEM, MEM/WB
// pipeline registers. Priority: data-memory wait > EX redirect > load-use.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   id_rs, id_rt, id_uses_rt   : ID-stage source operands
//   ex_mem_read, ex_write_reg  : EX-stage load indication and destination
//   ex_redirect                : taken branch / jump resolved in EX
//   mem_access, dmem_ready     : MEM-stage access and memory handshake
//   pc_enable, *_enable        : register load enables
//   *_flush                    : register flushes (override enables)
//   mem_timeout                : sticky fatal flag after a memory timeout
//   stall_count                : saturating count of cycles with pc_enable low
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_write_reg,
  input  logic             ex_redirect,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic             pc_enable,
  output logic             if_id_enable,
  output logic             id_ex_enable,
  output logic             ex_mem_enable,
  output logic             mem_wb_enable,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);
  localparam logic [WaitW-1:0] TimeoutCnt = WaitW'(TIMEOUT);

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d, wait_inc;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic             load_use;
  logic             waiting;

  hazard_detect u_hazard_detect (
    .id_rs_i        (id_rs),
    .id_rt_i        (id_rt),
    .id_uses_rt_i   (id_uses_rt),
    .ex_mem_read_i  (ex_mem_read),
    .ex_write_reg_i (ex_write_reg),
    .load_use_o     (load_use)
  );

  assign waiting = mem_access && !dmem_ready;

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StRun;
      wait_cnt_q    <= '0;
      stall_count_q <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_count_q <= stall_count_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    wait_inc   = wait_cnt_q + WaitW'(1);
    case (state_q)
      StRun: begin
        if (waiting) begin
          state_d    = StMemWait;
          wait_cnt_d = WaitW'(1);
        end
      end
      StMemWait: begin
        if (waiting) begin
          wait_cnt_d = wait_inc;
          // wait_cnt counts waiting cycles including this one.
          if (wait_inc == TimeoutCnt) state_d = StHalt;
        end else begin
          state_d    = StRun;
          wait_cnt_d = '0;
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StRun;
    endcase

    // The flag trails HALT entry by one cycle and stays until reset.
    mem_timeout_d = mem_timeout_q || (state_q == StHalt);

    stall_count_d = stall_count_q;
    if (!pc_enable && (stall_count_q != '1)) stall_count_d = stall_count_q + CNT_W'(1);
  end

  // Output logic.
  always_comb begin
    pc_enable     = 1'b1;
    if_id_enable  = 1'b1;
    id_ex_enable  = 1'b1;
    ex_mem_enable = 1'b1;
    mem_wb_enable = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    mem_wb_flush  = 1'b0;
    if (reset) begin
      pc_enable     = 1'b0;
      if_id_enable  = 1'b0;
      id_ex_enable  = 1'b0;
      ex_mem_enable = 1'b0;
      mem_wb_enable = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      ex_mem_flush  = 1'b1;
      mem_wb_flush  = 1'b1;
    end else if (state_q == StHalt) begin
      pc_enable     = 1'b0;
      if_id_enable  = 1'b0;
      id_ex_enable  = 1'b0;
      ex_mem_enable = 1'b0;
      mem_wb_enable = 1'b0;
    end else if (waiting) begin
      // Freeze everything up to MEM and feed a bubble into WB.
      pc_enable     = 1'b0;
      if_id_enable  = 1'b0;
      id_ex_enable  = 1'b0;
      ex_mem_enable = 1'b0;
      mem_wb_flush  = 1'b1;
    end else if (ex_redirect) begin
      // Squashes the wrong-path instructions, including any load-use consumer.
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
    end else if (load_use) begin
      pc_enable     = 1'b0;
      if_id_enable  = 1'b0;
      id_ex_flush   = 1'b1;
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign stall_count = stall_count_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC of the pipelined MIPS core.
- Drives every register's enable and flush from three conditions: multi-cycle data-memory wait, EX-stage control redirect, and load-use hazard.
- Tracks memory-wait duration, declares a fatal timeout, and keeps a saturating stall-cycle performance counter.

Parameters:
- TIMEOUT, 64, maximum consecutive MEM_WAIT cycles before fatal error (≥2).
- CNT_W, 16, width of stall_count.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source
- ex_mem_read  in  1  instruction in EX is a load
- ex_write_reg  in  5  destination register of the EX instruction
- ex_redirect  in  1  taken branch or jump resolved in EX
- mem_access  in  1  MEM stage holds a load or store
- dmem_ready  in  1  data memory completes the access this cycle
- pc_enable  out  1  PC load enable
- if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable  out  1 each  register enables
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  register flushes (flush overrides enable in the registers)
- mem_timeout  out  1  sticky fatal-error flag
- stall_count  out  CNT_W  saturating count of stalled cycles

Behaviour:
- FSM states: RUN, MEM_WAIT, HALT. Registers: state, wait_cnt (ceil(log2(TIMEOUT+1)) bits), stall_count, mem_timeout.
- Reset (synchronous): state=RUN, wait_cnt=0, stall_count=0, mem_timeout=0. While reset is high, the combinational outputs are forced to all enables=0 and all flushes=1.
- Control outputs are combinational from state and inputs, with zero latency.
- Default (no condition active): all enables=1, all flushes=0.
- Memory wait (highest priority):
  - Active when mem_access && !dmem_ready in RUN or MEM_WAIT.
  - Outputs: pc/if_id/id_ex/ex_mem enables=0, mem_wb_flush=1 (a bubble is inserted into WB), all other flushes=0.
  - In RUN, a wait moves the FSM to MEM_WAIT with wait_cnt=1.
  - In MEM_WAIT, wait_cnt increments each waiting cycle. On the cycle dmem_ready=1, outputs are default/other-condition values and the FSM returns to RUN with wait_cnt=0.
  - If wait_cnt==TIMEOUT while still waiting, the FSM moves to HALT.
- Redirect (second priority, RUN and not waiting): if_id_flush=1, id_ex_flush=1, pc_enable=1. Redirect wins over a simultaneous load-use, because the load-use consumer is squashed.
- Load-use (third priority): condition is ex_mem_read && ex_write_reg!=0 && (ex_write_reg==id_rs || (id_uses_rt && ex_write_reg==id_rt)). Outputs: pc_enable=0, if_id_enable=0, id_ex_flush=1, remaining enables=1. Exactly one bubble is inserted: the next cycle re-evaluates with the load in MEM.
- Redirect arriving during MEM_WAIT is not acted on. EX is frozen, so ex_redirect is held and takes effect on the release cycle, subject to the priority order above.
- HALT:
  - All enables=0, all flushes=0; the pipeline is frozen.
  - mem_timeout=1 from the cycle after HALT is entered, sticky until reset.
  - Only reset leaves HALT.
- stall_count increments by 1 on every cycle where pc_enable=0 (memory wait, load-use, or HALT) and saturates at all-ones. Reset clears it.
- Reset asserted mid-MEM_WAIT aborts the wait in the same cycle: outputs are forced as during reset, and state is RUN on the next cycle.

Decomposition:
- Shared package pipe_ctrl_pkg: state enum (RUN, MEM_WAIT, HALT) and the constant REG_ZERO=5'd0.
- One natural sub-module: hazard_detect, the purely combinational load-use comparator feeding the FSM.
- Counters and FSM stay in the top module.

Test Plan:
- Reset held 2 cycles → all flushes=1, enables=0, stall_count=0. After release with no hazards → all enables=1, flushes=0.
- Load-use: ex_mem_read=1, ex_write_reg=8, id_rs=8 → exactly 1 cycle of pc_enable=0, if_id_enable=0, id_ex_flush=1; stall_count=1. Repeat with ex_write_reg=0 → no stall.
- Redirect with simultaneous load-use (ex_redirect=1, hazard active) → if_id_flush=1, id_ex_flush=1, pc_enable=1, no stall counted.
- Memory wait: mem_access=1, dmem_ready=0 for 3 cycles, then 1 → 3 cycles of front enables=0 and mem_wb_flush=1. Release cycle has all enables=1; stall_count=3; state returns to RUN.
- Timeout with TIMEOUT=4: dmem_ready held 0 → HALT after 4 waiting cycles, mem_timeout=1 next cycle, everything frozen. Reset clears mem_timeout and state.
- Saturation with CNT_W=4: sustained HALT for 20 cycles → stall_count stops at 15.
